// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared states, default widths and payload field offsets for pipeline stage registers
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    localparam int PIPE_DATA_W = 160;
    localparam int PIPE_CNT_W  = 16;

    // Each stage payload is five 32-bit fields packed LSB-first
    localparam int FIELD_W  = 32;
    localparam int OFF_PC   = 0;
    localparam int OFF_IR   = 32;
    localparam int OFF_ALUO = 64;
    localparam int OFF_PC8  = 96;
    localparam int OFF_RT   = 128;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - valid/ready/data stream bundle between pipeline stages
interface pipe_stage_reg_if #(
    parameter int DATA_W = pipe_pkg::PIPE_DATA_W
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating up-counter, cleared only by rst
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with flush and stall counter; PIPE_SKID_EN adds a skid entry
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_stage_reg_if.slave  in_if,
    pipe_stage_reg_if.master out_if,
    output logic [CNT_W-1:0] stall_cnt
);
    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid;
    logic              in_ready;

    assign out_valid = (state_q != EMPTY);

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    // Depends only on state, so out_ready never reaches in_ready combinationally
    assign in_ready = (state_q != SKID);
`else
    assign in_ready = (state_q == EMPTY) || out_if.ready;
`endif

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
`ifdef PIPE_SKID_EN
        skid_data_d = skid_data_q;
`endif
        if (flush) begin
            state_d    = EMPTY;
            out_data_d = '0;
`ifdef PIPE_SKID_EN
            skid_data_d = '0;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_if.valid) begin
                        state_d    = FULL;
                        out_data_d = in_if.data;
                    end
                end
                FULL: begin
                    if (out_if.ready) begin
                        if (in_if.valid)
                            out_data_d = in_if.data;
                        else
                            state_d = EMPTY;
                    end
`ifdef PIPE_SKID_EN
                    else if (in_if.valid) begin
                        state_d     = SKID;
                        skid_data_d = in_if.data;
                    end
`endif
                end
                SKID: begin
`ifdef PIPE_SKID_EN
                    if (out_if.ready) begin
                        state_d    = FULL;
                        out_data_d = skid_data_q;
                    end
`else
                    state_d = EMPTY;
`endif
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
`ifdef PIPE_SKID_EN
            skid_data_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
`ifdef PIPE_SKID_EN
            skid_data_q <= skid_data_d;
`endif
        end
    end

    pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid && !out_if.ready),
        .cnt (stall_cnt)
    );

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = out_data_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - vector table, corner sequences and scoreboard for pipe_stage_reg (PIPE_SKID_EN aware)
module tb_pipe_stage_reg;
    import pipe_pkg::*;

`ifdef PIPE_SKID_EN
    localparam bit SK = 1'b1;
`else
    localparam bit SK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] stall_a;
    logic [2:0]  stall_b;

    pipe_stage_reg_if #(.DATA_W(160)) a_in ();
    pipe_stage_reg_if #(.DATA_W(160)) a_out ();
    pipe_stage_reg_if #(.DATA_W(8))   b_in ();
    pipe_stage_reg_if #(.DATA_W(8))   b_out ();

    pipe_stage_reg #(.DATA_W(160), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_if(a_in), .out_if(a_out), .stall_cnt(stall_a)
    );

    pipe_stage_reg #(.DATA_W(8), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_if(b_in), .out_if(b_out), .stall_cnt(stall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         fl;
        logic         iv;
        logic [159:0] d;
        logic         ordy;
        logic         e_ir;
        logic         e_ov;
        logic [159:0] e_od;
        logic [15:0]  e_st;
    } vec_t;

    vec_t           vecs[$];
    logic [159:0]   sb[$];
    int             checks = 0;
    int             errors = 0;
    int             n_emit = 0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic fl, input logic iv, input logic [159:0] d, input logic ordy,
                       input logic e_ir, input logic e_ov, input logic [159:0] e_od, input logic [15:0] e_st);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_st = e_st;
        vecs.push_back(v);
    endtask

    function automatic logic [159:0] mk_payload(input logic [31:0] v);
        logic [159:0] p;
        p = '0;
        p[OFF_PC   +: FIELD_W] = v;
        p[OFF_IR   +: FIELD_W] = ~v;
        p[OFF_ALUO +: FIELD_W] = v ^ 32'hA5A5_A5A5;
        p[OFF_PC8  +: FIELD_W] = v + 32'd8;
        p[OFF_RT   +: FIELD_W] = 32'h1F;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_emit(input string nm);
        if (a_out.valid && a_out.ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s: got emit %0h expected no emit (scoreboard empty)", nm, a_out.data);
            end else begin
                chk(nm, a_out.data, sb.pop_front());
                n_emit++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        a_in.valid = 1'b1; a_in.data = 160'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF; a_out.ready = 1'b1;
        b_in.valid = 1'b0; b_in.data = 8'h00; b_out.ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        a_in.valid = 1'b0;
        chk("rst_out_valid", a_out.valid, 0);
        chk("rst_out_data", a_out.data, 0);
        chk("rst_stall_cnt", stall_a, 0);
        chk("rst_in_ready", a_in.ready, 1);

        // streaming, then hold-while-empty
        add(0, 1, 1, 1, 1, 1, 1, 0);
        add(0, 1, 2, 1, 1, 1, 2, 0);
        add(0, 1, 3, 1, 1, 1, 3, 0);
        add(0, 1, 4, 1, 1, 1, 4, 0);
        add(0, 0, 0, 1, 1, 0, 4, 0);
        // load 5 then seven stalled cycles offering 6
        add(0, 1, 5, 0, 1, 1, 5, 0);
        for (int k = 1; k <= 7; k++)
            add(0, 1, 6, 0, SK && (k == 1), 1, 5, 16'(k));
        add(0, 0, 0, 1, !SK, SK, SK ? 160'h6 : 160'h5, 7);
        add(0, 0, 0, 1, 1, 0, SK ? 160'h6 : 160'h5, 7);
        // flush during stall with a simultaneous beat 9
        add(0, 1, 8, 0, 1, 1, 8, 7);
        add(0, 0, 0, 0, SK, 1, 8, 8);
        add(1, 1, 9, 0, SK, 0, 0, 9);
        add(0, 0, 0, 1, 1, 0, 0, 9);
        add(0, 0, 0, 1, 1, 0, 0, 9);
        add(0, 1, mk_payload(32'h1234_5678), 1, 1, 1, mk_payload(32'h1234_5678), 9);
        add(0, 0, 0, 1, 1, 0, mk_payload(32'h1234_5678), 9);
        // flush while a second beat is offered (held in skid when enabled)
        add(0, 1, 160'hA, 0, 1, 1, 160'hA, 9);
        add(0, 1, 160'hB, 0, SK, 1, 160'hA, 10);
        add(1, 0, 0, 0, 0, 0, 0, 11);
        add(0, 0, 0, 1, 1, 0, 0, 11);

        for (int i = 0; i < vecs.size(); i++) begin
            flush = vecs[i].fl; a_in.valid = vecs[i].iv; a_in.data = vecs[i].d; a_out.ready = vecs[i].ordy;
            #2;
            chk($sformatf("v%0d_in_ready", i), a_in.ready, vecs[i].e_ir);
            tick();
            chk($sformatf("v%0d_out_valid", i), a_out.valid, vecs[i].e_ov);
            chk($sformatf("v%0d_out_data", i), a_out.data, vecs[i].e_od);
            chk($sformatf("v%0d_stall_cnt", i), stall_a, vecs[i].e_st);
        end
        flush = 1'b0;

        // random valid/ready against an in-order scoreboard
        for (int c = 0; c < 400; c++) begin
            a_in.valid = ($urandom_range(0, 3) != 0);
            a_in.data = {128'b0, 32'(c + 100)};
            a_out.ready = ($urandom_range(0, 3) != 0);
            #2;
            check_emit("rand_order");
            if (a_in.valid && a_in.ready)
                sb.push_back(a_in.data);
            tick();
        end
        a_in.valid = 1'b0;
        a_out.ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            check_emit("drain_order");
            tick();
        end
        chk("rand_scoreboard_empty", 160'(sb.size()), 0);
        chk("rand_some_emitted", n_emit > 50, 1);

        // saturation with a 3-bit counter
        b_in.valid = 1'b1; b_in.data = 8'h3C; b_out.ready = 1'b0;
        tick();
        b_in.valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 7)
                chk("sat_cnt_at7", stall_b, 7);
        end
        chk("sat_cnt_at10", stall_b, 7);
        chk("sat_out_data", b_out.data, 8'h3C);
        chk("sat_out_valid", b_out.valid, 1);

        // reset in the middle of a stall
        a_in.valid = 1'b1; a_in.data = 160'h77; a_out.ready = 1'b0;
        repeat (3) tick();
        chk("midstall_valid_before_rst", a_out.valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_in.valid = 1'b0;
        chk("midrst_out_valid", a_out.valid, 0);
        chk("midrst_out_data", a_out.data, 0);
        chk("midrst_stall_cnt", stall_a, 0);
        chk("midrst_stall_b", stall_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, synchronous flush (bubble insertion) and a saturating back-pressure counter. It replaces the fixed per-stage latches between IF/ID/EX/MEM/WB. A stage's fields are concatenated into one payload bus. Downstream stalls propagate upstream by handshake rather than by ad-hoc enable wiring.

## Interface
- DATA_W, default 160: payload width, e.g. PC, IR, ALUO, PC8 and rt at 32 bits each.
- CNT_W, default 16: stall-counter width.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all held and incoming data this cycle.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data is a live instruction.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  registered payload.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- Accept: in_valid & in_ready. Emit: out_valid & out_ready.
- Base mode (no skid) has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
  - in_ready = !out_valid | out_ready, combinational.
  - EMPTY + accept -> FULL, and out_data <= in_data.
  - FULL + emit + accept -> FULL with new data (back-to-back, no bubble).
  - FULL + emit, no accept -> EMPTY.
  - FULL + !out_ready -> hold: out_data is unchanged and stable.
- Priority: rst > flush > handshake.
- Flush:
  - out_valid <= 0 and out_data <= 0. An all-zero IR is a nop.
  - Any beat accepted in the same cycle is dropped.
  - stall_cnt is unaffected.
- out_data holds its last value while EMPTY unless a flush clears it.
- stall_cnt increments by 1 each cycle with out_valid & !out_ready.
  - It saturates at 2^CNT_W-1.
  - Only rst clears it.

## Timing
- Reset values: out_valid=0, out_data=0, stall_cnt=0. in_ready=1 in the first cycle after reset.
- Latency: a beat accepted at edge N is visible on out_data/out_valid after edge N.
- Throughput: 1 beat/cycle while out_ready=1.
- Base mode has a combinational path out_ready -> in_ready. There is no combinational path in_* -> out_*.
- Flush and stall in the same cycle: flush wins; next cycle is out_valid=0.
- rst asserted mid-stall: all state clears at that edge; the stall count is lost.

## Configuration
- PIPE_SKID_EN defined: a second skid entry is added, making in_ready a registered output. This breaks the out_ready -> in_ready timing path.
  - States: EMPTY, FULL, SKID (two beats held).
  - in_ready = !skid_valid.
  - FULL + accept + !out_ready -> SKID: in_data goes to the skid slot.
  - SKID + emit -> FULL: the skid beat moves to out_data in order.
  - Flush clears both entries and zeroes both payloads.
  - Order is strictly FIFO.
- PIPE_SKID_EN undefined: the base two-state behaviour above applies, with no skid storage.

## Structure
- Shared package pipe_pkg holds:
  - the state enum (EMPTY, FULL, SKID);
  - the default width constants;
  - per-stage payload field offsets (PC, IR, ALUO, PC8, rt).
- Sub-module pipe_sat_counter (width parameter, inc, rst; saturating) implements stall_cnt.

## Test plan
- Reset: hold rst for 2 cycles with in_valid=1 and in_data=0xDEAD... -> out_valid=0, out_data=0, stall_cnt=0; in_ready=1 on the first post-reset cycle.
- Streaming: in_valid=1, out_ready=1, data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later, no gaps.
- Stall: load 0x5, then out_ready=0 for 7 cycles:
  - out_data stays 0x5 and stall_cnt=7.
  - Base mode: in_ready=0 throughout.
  - Skid mode: one extra beat 0x6 is accepted, then in_ready=0. Releasing out_ready yields 0x5 then 0x6.
- Flush during stall with a simultaneous in_valid beat 0x9 -> next cycle out_valid=0 and out_data=0; 0x9 never appears; stall_cnt keeps its value.
- Saturation with CNT_W=3: stall 10 cycles -> stall_cnt=7, with no wrap.
- Random valid/ready with a scoreboard, run in both macro settings -> every accepted non-flushed beat is emitted exactly once, in order.
